// File: rtl/brisc_pkg.sv
// brisc_pkg -- shared definitions for the program-memory loader.
//   SYNC_BYTE        : frame start marker
//   ld_state_t       : loader FSM state encoding
//   DEF_*            : default parameter values for prog_mem_loader
//   len_ok()         : frame length legality check against the memory depth
package brisc_pkg;

  localparam logic [7:0] SYNC_BYTE       = 8'hA5;
  localparam int         DEF_ADDR_W      = 5;
  localparam int         DEF_INSTR_W     = 16;
  localparam int         DEF_TIMEOUT_CYC = 100000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } ld_state_t;

  // A frame length is legal when it is non-zero and fits the memory.
  function automatic logic len_ok(input logic [7:0] n, input int unsigned addr_w);
    return (n != 8'd0) && (32'(n) <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/word_packer.sv
// word_packer -- assembles INSTR_W-bit words from a byte stream, MSB first.
// Ports:
//   CLK, RST_N   : clock, synchronous active-low reset
//   clr          : synchronous clear of byte index and shift register
//   byte_valid   : a byte is presented on byte_data this cycle
//   byte_data    : incoming byte
//   word_valid   : combinational, high in the cycle the last byte of a word arrives
//   word         : combinational, the completed word (meaningful with word_valid)
module word_packer #(
  parameter int INSTR_W = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               clr,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word
);

  localparam int BYTES = INSTR_W / 8;

  logic [3:0]         idx_r;
  logic [INSTR_W-1:0] shift_r;
  logic               last_s;

  // Word is formed from the bytes already held plus the one arriving now,
  // so the full word is available in the same cycle as its last byte.
  always_comb begin
    word   = (shift_r << 8) | INSTR_W'(byte_data);
    last_s = (idx_r == 4'(BYTES - 1));
    word_valid = byte_valid && last_s;
  end

  // Byte index and shift register.
  always_ff @(posedge CLK) begin
    if (!RST_N || clr) begin
      idx_r   <= 4'd0;
      shift_r <= {INSTR_W{1'b0}};
    end else if (byte_valid) begin
      shift_r <= word;
      idx_r   <= last_s ? 4'd0 : idx_r + 4'd1;
    end else begin
      idx_r   <= idx_r;
      shift_r <= shift_r;
    end
  end

endmodule

// File: rtl/prog_mem_loader.sv
// prog_mem_loader -- receives a framed program image over a UART byte stream
// and stores it in an instruction memory read combinationally by the core.
// Frame: SYNC(0xA5), LEN(N), N*INSTR_W/8 data bytes MSB-first, [CSUM].
// Build option: define CHECKSUM_EN to expect and check a trailing
// modulo-256 sum of the data bytes; without it the frame ends after data.
// Ports:
//   CLK, RST_N       : clock, synchronous active-low reset
//   rx_valid/rx_data : received byte strobe and value (from rxuartlite o_wr/o_data)
//   reload           : discard image state and re-arm the loader
//   program_counter  : memory read address
//   instruction      : mem[program_counter], 0 until an image is complete
//   load_done        : image complete and valid
//   load_busy        : frame in progress
//   load_err         : frame rejected
//   words_loaded     : words written in the current frame
module prog_mem_loader
  import brisc_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int INSTR_W     = DEF_INSTR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               reload,
  input  logic [ADDR_W-1:0]  program_counter,
  output logic [INSTR_W-1:0] instruction,
  output logic               load_done,
  output logic               load_busy,
  output logic               load_err,
  output logic [7:0]         words_loaded
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int DEPTH = 1 << ADDR_W;

  ld_state_t          state_r, state_nx_s;
  logic               done_r, err_r, busy_r;
  logic [7:0]         words_r, len_r;
  logic [TMO_W-1:0]   tmo_r;
  logic               tmo_hit_s, wr_en_s, pk_valid_s, word_valid_s;
  logic [INSTR_W-1:0] word_s;
  logic [INSTR_W-1:0] mem_r [DEPTH];
`ifdef CHECKSUM_EN
  logic [7:0]         sum_r;
`endif

  assign tmo_hit_s  = (tmo_r == TMO_W'(TIMEOUT_CYC - 1));
  assign pk_valid_s = rx_valid && !reload && (state_r == ST_DATA);

  word_packer #(.INSTR_W(INSTR_W)) u_packer (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .clr        (reload),
    .byte_valid (pk_valid_s),
    .byte_data  (rx_data),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // Next-state logic and memory write enable.
  always_comb begin
    state_nx_s = state_r;
    wr_en_s    = 1'b0;
    if (reload) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) state_nx_s = ST_LEN;
          else                                     state_nx_s = ST_IDLE;
        end
        ST_LEN: begin
          if (rx_valid) state_nx_s = len_ok(rx_data, ADDR_W) ? ST_DATA : ST_ERR;
          else if (tmo_hit_s) state_nx_s = ST_ERR;
          else state_nx_s = ST_LEN;
        end
        ST_DATA: begin
          if (word_valid_s) begin
            wr_en_s = 1'b1;
            if (words_r == len_r - 8'd1) begin
`ifdef CHECKSUM_EN
              state_nx_s = ST_CSUM;
`else
              state_nx_s = ST_DONE;
`endif
            end else begin
              state_nx_s = ST_DATA;
            end
          end else if (!rx_valid && tmo_hit_s) begin
            state_nx_s = ST_ERR;
          end else begin
            state_nx_s = ST_DATA;
          end
        end
`ifdef CHECKSUM_EN
        ST_CSUM: begin
          if (rx_valid) state_nx_s = (rx_data == sum_r) ? ST_DONE : ST_ERR;
          else if (tmo_hit_s) state_nx_s = ST_ERR;
          else state_nx_s = ST_CSUM;
        end
`endif
        ST_DONE: state_nx_s = ST_DONE;
        ST_ERR:  state_nx_s = ST_ERR;
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // State, status outputs, counters. Reset and reload share one clear path.
  always_ff @(posedge CLK) begin
    if (!RST_N || reload) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      words_r <= 8'd0;
      len_r   <= 8'd0;
      tmo_r   <= {TMO_W{1'b0}};
`ifdef CHECKSUM_EN
      sum_r   <= 8'd0;
`endif
    end else begin
      state_r <= state_nx_s;
      done_r  <= (state_nx_s == ST_DONE);
      err_r   <= (state_nx_s == ST_ERR);
      busy_r  <= (state_nx_s == ST_LEN) || (state_nx_s == ST_DATA) ||
                 (state_nx_s == ST_CSUM);
      words_r <= wr_en_s ? words_r + 8'd1 : words_r;
      len_r   <= (state_r == ST_LEN && rx_valid) ? rx_data : len_r;
      // Idle timer only runs while a frame is open; any byte restarts it.
      if ((state_r == ST_LEN || state_r == ST_DATA || state_r == ST_CSUM) && !rx_valid)
        tmo_r <= tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
      else
        tmo_r <= {TMO_W{1'b0}};
`ifdef CHECKSUM_EN
      sum_r   <= pk_valid_s ? sum_r + rx_data : sum_r;
`endif
    end
  end

  // Instruction memory; deliberately not reset so an aborted load keeps contents.
  always_ff @(posedge CLK) begin
    if (RST_N && wr_en_s) mem_r[words_r[ADDR_W-1:0]] <= word_s;
    else                  mem_r[words_r[ADDR_W-1:0]] <= mem_r[words_r[ADDR_W-1:0]];
  end

  assign instruction  = done_r ? mem_r[program_counter] : {INSTR_W{1'b0}};
  assign load_done    = done_r;
  assign load_err     = err_r;
  assign load_busy    = busy_r;
  assign words_loaded = words_r;

endmodule

// File: doc/prog_mem_loader.md
PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, word-address width; legal range 1..8.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width; must be a multiple of 8, range 8..64; BYTES = INSTR_W/8.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 100000, maximum idle cycles allowed between bytes inside a frame.
REQ-004 SHALL have port CLK  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port RST_N  in  1  synchronous, active-low reset.
REQ-006 SHALL have port rx_valid  in  1  one-cycle strobe marking a received UART byte.
REQ-007 SHALL have port rx_data  in  8  received byte, valid with rx_valid.
REQ-008 SHALL have port reload  in  1  pulse that discards the current image state and re-arms the loader.
REQ-009 SHALL have port program_counter  in  ADDR_W  read address.
REQ-010 SHALL have port instruction  out  INSTR_W  mem[program_counter], combinational; forced to 0 (NOP) while load_done=0.
REQ-011 SHALL have port load_done  out  1  image complete and valid.
REQ-012 SHALL have port load_busy  out  1  frame in progress.
REQ-013 SHALL have port load_err  out  1  frame rejected.
REQ-014 SHALL have port words_loaded  out  8  count of words written in the current frame.

Function
REQ-015 SHALL frame the input as SYNC(0xA5), LEN(N), N*BYTES data bytes (MSB first per word), then CSUM.
REQ-016 SHALL implement states IDLE, LEN, DATA, CSUM, DONE, ERR.
REQ-017 SHALL, in IDLE, ignore every byte other than 0xA5; 0xA5 moves the FSM to LEN.
REQ-018 SHALL, in LEN, go to ERR if N=0 or N>2**ADDR_W, otherwise latch N and go to DATA.
REQ-019 SHALL, in DATA, pack bytes MSB-first and write the word to mem[words_loaded] in the cycle its last byte arrives, then increment words_loaded.
REQ-020 SHALL leave the DATA state after N words are written.
REQ-021 SHALL keep an 8-bit modulo-256 running sum of all data bytes.
REQ-022 SHALL, in CSUM, go to DONE when the byte equals the sum and to ERR otherwise.
REQ-023 SHALL register load_done/load_err, asserting them the cycle after the deciding byte.
REQ-024 SHALL hold load_busy=1 in LEN, DATA and CSUM only.
REQ-025 SHALL, in LEN, DATA or CSUM, go to ERR when TIMEOUT_CYC cycles pass without rx_valid; the counter restarts on every accepted byte.
REQ-026 SHALL ignore rx_valid in DONE and ERR; both states exit only via reload or reset.
REQ-027 SHALL, on reload, go to IDLE next cycle and clear load_done, load_err, words_loaded, the sum and the packer.
REQ-028 SHALL give reload priority over a same-cycle rx_valid, discarding that byte.
REQ-029 SHALL leave words at addresses >= N unchanged.
REQ-030 SHALL retain partially written contents after an aborted frame, with instruction kept gated to 0.

Reset
REQ-031 SHALL, while RST_N=0 at a CLK edge, put the FSM in IDLE and set load_done=0, load_busy=0, load_err=0, words_loaded=0, sum=0, packer byte index=0 and timeout counter=0.
REQ-032 SHALL NOT reset memory contents; reset mid-frame behaves as reload.

Configuration
REQ-033 SHALL, when CHECKSUM_EN is defined, implement the CSUM state and checksum check exactly as above.
REQ-034 SHALL, when CHECKSUM_EN is undefined, omit the CSUM state and the sum register, and go from DATA to DONE once the last word is written; no checksum byte is expected.

Structure
REQ-035 SHALL place SYNC_BYTE=8'hA5, the state encoding typedef and the default parameter values in shared package brisc_pkg.
REQ-036 SHALL use one sub-module, word_packer, holding the byte index and shift register and producing word_valid/word.
REQ-037 SHALL connect its byte source externally to the existing rxuartlite o_wr/o_data.

Verification
REQ-038 SHALL check, with defaults and CHECKSUM_EN, that A5 02 40 08 41 02 8B gives load_done=1, words_loaded=2, and instruction 16'h4008 at PC=0 and 16'h4102 at PC=1.
REQ-039 SHALL check that the same frame with CSUM=8C gives load_err=1, load_done=0, and instruction 0 at every PC.
REQ-040 SHALL check that A5 21 gives load_err=1 the cycle after LEN (33>32), and that A5 00 also gives ERR.
REQ-041 SHALL check that A5 01 40 followed by TIMEOUT_CYC idle cycles gives load_err=1 and load_busy=0.
REQ-042 SHALL check that reload asserted with rx_valid mid-DATA gives IDLE, the byte dropped, and that a fresh valid frame then completes.
REQ-043 SHALL check that RST_N=0 mid-frame clears all outputs, keeps memory, and that a garbage byte 0x40 in IDLE is ignored.
